// File: rtl/pipe_spawn_scheduler.sv
// pipe_spawn_scheduler
// Paces pipe spawns off the frame tick, steps the 4-bit random pattern source
// once per draw, rejects gap rows that cannot be rendered (with a bounded number
// of redraws and a fixed fallback row), and offers each accepted gap row to the
// pipe renderer over a valid/ready handshake.
module pipe_spawn_scheduler #(
    parameter int SPAWN_PERIOD = 12,
    parameter int MAX_GAP      = 11,
    parameter int MAX_RETRY    = 3,
    parameter int FALLBACK_GAP = 6
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       run,
    input  logic       tick,
    input  logic [3:0] rand_value,
    output logic       rand_step,
    output logic       spawn_valid,
    output logic [3:0] spawn_gap,
    input  logic       spawn_ready,
    output logic [7:0] spawn_count,
    output logic       busy
);

    // A period of one tick still needs a 1-bit counter so the compare is legal.
    localparam int TICK_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int ATT_W  = $clog2(MAX_RETRY + 1);

    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(SPAWN_PERIOD - 1);
    localparam logic [ATT_W-1:0]  ATT_MAX      = ATT_W'(MAX_RETRY);
    localparam logic [3:0]        GAP_MAX      = 4'(MAX_GAP);
    localparam logic [3:0]        GAP_FALLBACK = 4'(FALLBACK_GAP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DRAW  = 3'd2,
        CHECK = 3'd3,
        OFFER = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_cnt_nxt;
    logic [ATT_W-1:0]    attempts;
    logic [ATT_W-1:0]    attempts_nxt;
    logic [3:0]          gap_reg;
    logic [3:0]          gap_reg_nxt;
    logic [7:0]          count_reg;
    logic [7:0]          count_reg_nxt;

    // Accepted-pipe counter sticks at its ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Draws above the largest renderable row are rejected (unsigned 4-bit compare).
    function automatic logic gap_in_range(input logic [3:0] v);
        return v <= GAP_MAX;
    endfunction

    // Next-state and register updates; run low anywhere outside IDLE aborts to IDLE.
    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        attempts_nxt  = attempts;
        gap_reg_nxt   = gap_reg;
        count_reg_nxt = count_reg;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt     = COUNT;
                    tick_cnt_nxt  = '0;
                    count_reg_nxt = '0;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_nxt    = DRAW;
                        tick_cnt_nxt = '0;
                        attempts_nxt = '0;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            DRAW: begin
                attempts_nxt = attempts + 1'b1;
                state_nxt    = run ? CHECK : IDLE;
            end
            CHECK: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (gap_in_range(rand_value)) begin
                    gap_reg_nxt = rand_value;
                    state_nxt   = OFFER;
                end else if (attempts < ATT_MAX) begin
                    state_nxt = DRAW;
                end else begin
                    gap_reg_nxt = GAP_FALLBACK;
                    state_nxt   = OFFER;
                end
            end
            OFFER: begin
                // A handshake in the cycle run falls still counts the pipe.
                if (spawn_ready) begin
                    count_reg_nxt = sat_inc8(count_reg);
                    tick_cnt_nxt  = '0;
                    state_nxt     = run ? COUNT : IDLE;
                end else if (!run) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; outputs are registered decodes of the state being entered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            attempts    <= '0;
            gap_reg     <= '0;
            count_reg   <= '0;
            rand_step   <= 1'b0;
            spawn_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            attempts    <= attempts_nxt;
            gap_reg     <= gap_reg_nxt;
            count_reg   <= count_reg_nxt;
            rand_step   <= (state_nxt == DRAW);
            spawn_valid <= (state_nxt == OFFER);
            busy        <= (state_nxt != IDLE);
        end
    end

    assign spawn_gap   = gap_reg;
    assign spawn_count = count_reg;

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// Bench for pipe_spawn_scheduler: default-parameter instance for pacing, redraw,
// fallback, back-pressure, abort and reset; a one-tick-period instance for
// spawn_count saturation.
module tb_pipe_spawn_scheduler;

    localparam int SP = 12;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       run = 1'b0;
    logic       tick = 1'b0;
    logic       spawn_ready = 1'b0;
    logic [3:0] rand_value = 4'd0;
    logic       rand_step;
    logic       spawn_valid;
    logic [3:0] spawn_gap;
    logic [7:0] spawn_count;
    logic       busy;

    logic       run1 = 1'b0;
    logic       tick1 = 1'b0;
    logic       ready1 = 1'b0;
    logic [3:0] rv1 = 4'd5;
    logic       step1;
    logic       valid1;
    logic [3:0] gap1;
    logic [7:0] count1;
    logic       busy1;

    int errors = 0;
    int checks = 0;
    int hs1 = 0;

    logic [3:0] rand_seq[$];
    logic [3:0] sb[$];
    logic       prev_step = 1'b0;
    bit         quiet_ok;

    typedef struct packed {
        logic [1:0] n;
        logic [3:0] v0;
        logic [3:0] v1;
        logic [3:0] v2;
        logic [3:0] gap;
        logic [3:0] steps;
        logic [3:0] lat;
    } vec_t;

    vec_t tbl[6];

    pipe_spawn_scheduler u_dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .run         (run),
        .tick        (tick),
        .rand_value  (rand_value),
        .rand_step   (rand_step),
        .spawn_valid (spawn_valid),
        .spawn_gap   (spawn_gap),
        .spawn_ready (spawn_ready),
        .spawn_count (spawn_count),
        .busy        (busy)
    );

    pipe_spawn_scheduler #(.SPAWN_PERIOD(1)) u_fast (
        .Clock       (Clock),
        .Reset       (Reset),
        .run         (run1),
        .tick        (tick1),
        .rand_value  (rv1),
        .rand_step   (step1),
        .spawn_valid (valid1),
        .spawn_gap   (gap1),
        .spawn_ready (ready1),
        .spawn_count (count1),
        .busy        (busy1)
    );

    always #5 Clock = ~Clock;

    // Random source model: advances to its next queued value on each step pulse.
    always @(posedge Clock) begin
        if (rand_step && rand_seq.size() > 0) rand_value <= rand_seq.pop_front();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard and pulse-spacing monitor, sampled mid-cycle.
    always @(negedge Clock) begin
        if (rand_step) check("step_not_back_to_back", prev_step, 1'b0);
        prev_step = rand_step;
        if (spawn_valid && spawn_ready) begin
            if (sb.size() == 0) check("sb_unexpected_handshake", 1, 0);
            else check("sb_gap", spawn_gap, sb.pop_front());
        end
        if (valid1 && ready1) hs1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clk();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk();
        tick = 1'b0;
        if (rand_step || spawn_valid) quiet_ok = 1'b0;
        repeat (3) begin
            clk();
            if (rand_step || spawn_valid) quiet_ok = 1'b0;
        end
    endtask

    // SP-1 quiet ticks, then the period-completing tick; returns in cycle t+1.
    task automatic period_ticks();
        quiet_ok = 1'b1;
        repeat (SP - 1) do_tick();
        check("quiet_before_period", quiet_ok, 1'b1);
        tick = 1'b1;
        clk();
        tick = 1'b0;
    endtask

    // Runs a full period and waits (bounded) for the offer; returns in the first OFFER cycle.
    task automatic spawn_to_offer(output int lat, output int steps);
        period_ticks();
        lat = 0;
        steps = 0;
        for (int i = 1; i <= 12; i++) begin
            if (rand_step) steps++;
            if (spawn_valid) begin
                lat = i;
                break;
            end
            clk();
        end
    endtask

    initial begin
        int lat;
        int steps;
        bit stable;
        bit count_ok;
        int exp_cnt;

        tbl[0] = '{2'd1, 4'd5,  4'd0,  4'd0,  4'd5,  4'd1, 4'd3};
        tbl[1] = '{2'd3, 4'd14, 4'd13, 4'd9,  4'd9,  4'd3, 4'd7};
        tbl[2] = '{2'd3, 4'd15, 4'd15, 4'd15, 4'd6,  4'd3, 4'd7};
        tbl[3] = '{2'd2, 4'd12, 4'd11, 4'd0,  4'd11, 4'd2, 4'd5};
        tbl[4] = '{2'd1, 4'd0,  4'd0,  4'd0,  4'd0,  4'd1, 4'd3};
        tbl[5] = '{2'd2, 4'd15, 4'd0,  4'd0,  4'd0,  4'd2, 4'd5};

        // Reset state
        Reset = 1'b1;
        repeat (2) clk();
        check("rst_busy", busy, 0);
        check("rst_valid", spawn_valid, 0);
        check("rst_step", rand_step, 0);
        check("rst_gap", spawn_gap, 0);
        check("rst_count", spawn_count, 0);
        Reset = 1'b0;
        clk();
        check("idle_busy", busy, 0);

        // Game start
        run = 1'b1;
        spawn_ready = 1'b1;
        clk();
        check("start_busy", busy, 1);
        check("start_count", spawn_count, 0);

        // Table: draw sequences, accepted/fallback rows, latency and pulse counts
        for (int i = 0; i < 6; i++) begin
            rand_seq.delete();
            if (tbl[i].n >= 1) rand_seq.push_back(tbl[i].v0);
            if (tbl[i].n >= 2) rand_seq.push_back(tbl[i].v1);
            if (tbl[i].n >= 3) rand_seq.push_back(tbl[i].v2);
            sb.push_back(tbl[i].gap);
            spawn_to_offer(lat, steps);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_steps", i), steps, tbl[i].steps);
            check($sformatf("vec%0d_gap", i), spawn_gap, tbl[i].gap);
            clk();
            check($sformatf("vec%0d_valid_drop", i), spawn_valid, 0);
            check($sformatf("vec%0d_count", i), spawn_count, i + 1);
        end

        // Back-pressure: ready low for 50 cycles while ticks keep coming
        spawn_ready = 1'b0;
        rand_seq.delete();
        rand_seq.push_back(4'd3);
        sb.push_back(4'd3);
        spawn_to_offer(lat, steps);
        check("hold_latency", lat, 3);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick = (i % 4 == 0);
            clk();
            if (!spawn_valid || spawn_gap !== 4'd3 || rand_step) stable = 1'b0;
        end
        tick = 1'b0;
        check("hold_stable", stable, 1);
        spawn_ready = 1'b1;
        clk();
        check("hold_release_valid", spawn_valid, 0);
        check("hold_release_count", spawn_count, 7);
        rand_seq.delete();
        rand_seq.push_back(4'd4);
        sb.push_back(4'd4);
        spawn_to_offer(lat, steps);
        check("after_hold_latency", lat, 3);
        check("after_hold_steps", steps, 1);
        clk();
        check("after_hold_count", spawn_count, 8);

        // Abort in OFFER
        spawn_ready = 1'b0;
        rand_seq.delete();
        rand_seq.push_back(4'd7);
        spawn_to_offer(lat, steps);
        check("abort_offer_valid_before", spawn_valid, 1);
        run = 1'b0;
        clk();
        check("abort_offer_busy", busy, 0);
        check("abort_offer_valid", spawn_valid, 0);
        check("abort_offer_count", spawn_count, 8);
        check("abort_offer_gap", spawn_gap, 7);
        clk();
        check("abort_offer_stay_idle", busy, 0);
        run = 1'b1;
        spawn_ready = 1'b1;
        clk();
        check("restart_busy", busy, 1);
        check("restart_count", spawn_count, 0);
        rand_seq.delete();
        rand_seq.push_back(4'd2);
        sb.push_back(4'd2);
        spawn_to_offer(lat, steps);
        clk();
        check("restart_spawn_count", spawn_count, 1);

        // Abort in DRAW
        rand_seq.delete();
        rand_seq.push_back(4'd8);
        period_ticks();
        check("draw_step_seen", rand_step, 1);
        run = 1'b0;
        clk();
        check("abort_draw_busy", busy, 0);
        check("abort_draw_valid", spawn_valid, 0);
        check("abort_draw_step", rand_step, 0);
        check("abort_draw_count", spawn_count, 1);

        // Handshake in the cycle run falls
        run = 1'b1;
        clk();
        spawn_ready = 1'b0;
        rand_seq.delete();
        rand_seq.push_back(4'd3);
        sb.push_back(4'd3);
        spawn_to_offer(lat, steps);
        run = 1'b0;
        spawn_ready = 1'b1;
        clk();
        check("runfall_busy", busy, 0);
        check("runfall_valid", spawn_valid, 0);
        check("runfall_count", spawn_count, 1);

        // Reset in CHECK
        run = 1'b1;
        clk();
        rand_seq.delete();
        rand_seq.push_back(4'd5);
        sb.push_back(4'd5);
        spawn_to_offer(lat, steps);
        clk();
        check("prereset_count", spawn_count, 1);
        rand_seq.delete();
        rand_seq.push_back(4'd5);
        period_ticks();
        clk();
        Reset = 1'b1;
        clk();
        check("midcheck_rst_busy", busy, 0);
        check("midcheck_rst_valid", spawn_valid, 0);
        check("midcheck_rst_step", rand_step, 0);
        check("midcheck_rst_gap", spawn_gap, 0);
        check("midcheck_rst_count", spawn_count, 0);
        Reset = 1'b0;
        run = 1'b0;
        clk();

        // Saturation on the one-tick-period instance
        run1 = 1'b1;
        tick1 = 1'b1;
        ready1 = 1'b1;
        count_ok = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            clk();
            exp_cnt = (hs1 > 255) ? 255 : hs1;
            if (count1 !== 8'(exp_cnt)) count_ok = 1'b0;
        end
        check("sat_handshakes_enough", (hs1 >= 260), 1);
        check("sat_count_tracks", count_ok, 1);
        check("sat_count_final", count1, 255);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
